// File: rtl/view_splitter_if.sv
// rtl/view_splitter_if.sv - raster in / parallel-view out signal bundle for view_splitter
interface view_splitter_if #(
    parameter int N_VIEWS = 2,
    parameter int PIX_W   = 24
);
    logic                       de_in;
    logic                       h_sync_in;
    logic                       v_sync_in;
    logic [PIX_W-1:0]           pixel_in;
    logic                       de_out;
    logic                       h_sync_out;
    logic                       v_sync_out;
    logic [N_VIEWS*PIX_W-1:0]   pixel_out;
    logic                       line_err;

    modport master (
        output de_in, h_sync_in, v_sync_in, pixel_in,
        input  de_out, h_sync_out, v_sync_out, pixel_out, line_err
    );

    modport slave (
        input  de_in, h_sync_in, v_sync_in, pixel_in,
        output de_out, h_sync_out, v_sync_out, pixel_out, line_err
    );
endinterface

// File: rtl/view_splitter.sv
// rtl/view_splitter.sv - splits N side-by-side views of a raster line into column-aligned parallel pixels
module view_splitter #(
    parameter int H_ACTIVE = 128,
    parameter int N_VIEWS  = 2,
    parameter int PIX_W    = 24
) (
    input  logic            clk,
    input  logic            rst,
    view_splitter_if.slave  bus
);
    localparam int W      = H_ACTIVE / N_VIEWS;
    localparam int SEG_W  = $clog2(N_VIEWS);
    localparam int ADDR_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [SEG_W-1:0]  LAST_SEG  = SEG_W'(N_VIEWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W - 1);

    generate
        if (N_VIEWS < 2 || (H_ACTIVE % N_VIEWS) != 0) begin : g_bad_params
            $error("view_splitter: N_VIEWS must be >= 2 and divide H_ACTIVE");
        end
    endgenerate

    logic [SEG_W-1:0]  seg;
    logic [ADDR_W-1:0] addr;
    logic              full;
    logic              ovf;
    logic              ignore;
    logic              in_run;
    logic              err_q;
    logic              accept;
    logic              wr_en;
    logic              rd_en;

    // ignore blocks the tail of a run that was already in progress across a reset
    assign accept = bus.de_in && !ignore && !full;
    assign wr_en  = accept && (seg != LAST_SEG);
    assign rd_en  = accept && (seg == LAST_SEG);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg    <= '0;
            addr   <= '0;
            full   <= 1'b0;
            ovf    <= 1'b0;
            in_run <= 1'b0;
            ignore <= bus.de_in;
            err_q  <= 1'b0;
        end else begin
            err_q <= in_run && !bus.de_in && (ovf || !full);
            if (!bus.de_in) begin
                seg    <= '0;
                addr   <= '0;
                full   <= 1'b0;
                ovf    <= 1'b0;
                in_run <= 1'b0;
                ignore <= 1'b0;
            end else if (accept) begin
                in_run <= 1'b1;
                if (addr == LAST_ADDR) begin
                    addr <= '0;
                    if (seg == LAST_SEG) full <= 1'b1;
                    else                 seg  <= seg + 1'b1;
                end else begin
                    addr <= addr + 1'b1;
                end
            end else if (full && !ignore) begin
                ovf <= 1'b1;
            end
        end
    end

    logic [(N_VIEWS-1)*PIX_W-1:0] rd_all;

    generate
        for (genvar b = 0; b < N_VIEWS - 1; b++) begin : g_bank
            logic [PIX_W-1:0] mem [W];
            logic [PIX_W-1:0] rd;
            always_ff @(posedge clk) begin
                if (wr_en && seg == SEG_W'(b)) mem[addr] <= bus.pixel_in;
                if (rd_en) rd <= mem[addr];
            end
            assign rd_all[b*PIX_W +: PIX_W] = rd;
        end
    endgenerate

    logic                     vld_d1;
    logic [PIX_W-1:0]         pix_d1;
    logic                     de_q;
    logic [N_VIEWS*PIX_W-1:0] pixel_q;
    logic [1:0]               hs_d;
    logic [1:0]               vs_d;

    // the live pixel is the last view, so it is delayed alongside the bank read
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_d1  <= 1'b0;
            pix_d1  <= '0;
            de_q    <= 1'b0;
            pixel_q <= '0;
            hs_d    <= '0;
            vs_d    <= '0;
        end else begin
            vld_d1 <= rd_en;
            if (rd_en) pix_d1 <= bus.pixel_in;
            de_q <= vld_d1;
            if (vld_d1) pixel_q <= {pix_d1, rd_all};
            hs_d <= {hs_d[0], bus.h_sync_in};
            vs_d <= {vs_d[0], bus.v_sync_in};
        end
    end

    assign bus.de_out     = de_q;
    assign bus.pixel_out  = pixel_q;
    assign bus.h_sync_out = hs_d[1];
    assign bus.v_sync_out = vs_d[1];
    assign bus.line_err   = err_q;
endmodule

// File: tb/tb_view_splitter.sv
// tb/tb_view_splitter.sv - randomized scoreboard bench for view_splitter with 2- and 4-view instances
module tb_view_splitter;
    localparam int H  = 64;
    localparam int PW = 24;
    typedef logic [4*PW-1:0] wide_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          de  = 1'b0;
    logic          hs  = 1'b0;
    logic          vs  = 1'b0;
    logic [PW-1:0] pix = '0;
    int            tests = 0;
    int            fails = 0;
    int            cyc = 0;
    int            line_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    view_splitter_if #(.N_VIEWS(2), .PIX_W(PW)) if2 ();
    view_splitter_if #(.N_VIEWS(4), .PIX_W(PW)) if4 ();

    assign if2.de_in = de;  assign if2.h_sync_in = hs;  assign if2.v_sync_in = vs;  assign if2.pixel_in = pix;
    assign if4.de_in = de;  assign if4.h_sync_in = hs;  assign if4.v_sync_in = vs;  assign if4.pixel_in = pix;

    view_splitter #(.H_ACTIVE(H), .N_VIEWS(2), .PIX_W(PW)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    view_splitter #(.H_ACTIVE(H), .N_VIEWS(4), .PIX_W(PW)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));

    logic [2*PW-1:0] q2 [$];
    logic [4*PW-1:0] q4 [$];
    int              t2_q [$];
    int              t4_q [$];
    int              err2_q [$];
    int              err4_q [$];

    task automatic check(input string name, input wide_t act, input wide_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if ($urandom_range(0, 3) == 0) hs = ~hs;
        if ($urandom_range(0, 4) == 0) vs = ~vs;
    endtask

    logic [1:0] rst_h = '1;
    logic [1:0] hs_h  = '0;
    logic [1:0] vs_h  = '0;
    always @(posedge clk) begin
        rst_h <= {rst_h[0], rst};
        hs_h  <= {hs_h[0], hs};
        vs_h  <= {vs_h[0], vs};
    end

    logic [2*PW-1:0] e2;
    logic [4*PW-1:0] e4;
    logic            ex_h;
    logic            ex_v;
    always @(negedge clk) begin
        if (cyc >= 3) begin
            ex_h = (rst_h[0] | rst_h[1]) ? 1'b0 : hs_h[1];
            ex_v = (rst_h[0] | rst_h[1]) ? 1'b0 : vs_h[1];
            check("n2 h_sync_out", wide_t'(if2.h_sync_out), wide_t'(ex_h));
            check("n2 v_sync_out", wide_t'(if2.v_sync_out), wide_t'(ex_v));
            check("n4 h_sync_out", wide_t'(if4.h_sync_out), wide_t'(ex_h));
            check("n4 v_sync_out", wide_t'(if4.v_sync_out), wide_t'(ex_v));
        end
        if (if2.de_out) begin
            if (q2.size() == 0) check("n2 unexpected de_out", 1, 0);
            else begin
                e2 = q2.pop_front();
                check("n2 pixel_out", wide_t'(if2.pixel_out), wide_t'(e2));
                check("n2 de_out cycle", wide_t'(cyc), wide_t'(t2_q.pop_front()));
            end
        end
        if (if4.de_out) begin
            if (q4.size() == 0) check("n4 unexpected de_out", 1, 0);
            else begin
                e4 = q4.pop_front();
                check("n4 pixel_out", if4.pixel_out, e4);
                check("n4 de_out cycle", wide_t'(cyc), wide_t'(t4_q.pop_front()));
            end
        end
        if (if2.line_err) begin
            if (err2_q.size() == 0) check("n2 unexpected line_err", 1, 0);
            else check("n2 line_err cycle", wide_t'(cyc), wide_t'(err2_q.pop_front()));
        end
        if (if4.line_err) begin
            if (err4_q.size() == 0) check("n4 unexpected line_err", 1, 0);
            else check("n4 line_err cycle", wide_t'(cyc), wide_t'(err4_q.pop_front()));
        end
    end

    task automatic check_zero(input string tag);
        check({tag, " n2 de_out"},     wide_t'(if2.de_out),     0);
        check({tag, " n2 pixel_out"},  wide_t'(if2.pixel_out),  0);
        check({tag, " n2 line_err"},   wide_t'(if2.line_err),   0);
        check({tag, " n4 de_out"},     wide_t'(if4.de_out),     0);
        check({tag, " n4 pixel_out"},  wide_t'(if4.pixel_out),  0);
        check({tag, " n4 line_err"},   wide_t'(if4.line_err),   0);
    endtask

    // mode 0: random pixels, 1: column index, 2: {A0+line, 00, col}; rst_col < 0 means no reset
    task automatic send_line(input int run, input int mode, input int rst_col);
        logic [PW-1:0]   px [$];
        logic [2*PW-1:0] v2;
        logic [4*PW-1:0] v4;
        int              lim;
        for (int c = 0; c < run; c++) begin
            case (mode)
                0:       px.push_back(PW'($urandom));
                1:       px.push_back(PW'(c));
                default: px.push_back({8'hA0 + 8'(line_no), 8'h00, 8'(c)});
            endcase
        end
        // a reset aborts everything not yet on the output when it is sampled
        lim = (run < H) ? run : H;
        if (rst_col >= 0 && rst_col - 1 < lim) lim = rst_col - 1;
        for (int k = 0; H/2 + k < lim; k++) begin
            for (int v = 0; v < 2; v++) v2[v*PW +: PW] = px[v*(H/2) + k];
            q2.push_back(v2);
        end
        for (int k = 0; 3*(H/4) + k < lim; k++) begin
            for (int v = 0; v < 4; v++) v4[v*PW +: PW] = px[v*(H/4) + k];
            q4.push_back(v4);
        end
        for (int c = 0; c < run; c++) begin
            step();
            de  = 1'b1;
            pix = px[c];
            rst = (c == rst_col || c == rst_col + 1) && rst_col >= 0;
            if (c >= H/2 && c < lim) t2_q.push_back(cyc + 2);
            if (c >= 3*(H/4) && c < lim) t4_q.push_back(cyc + 2);
            if (rst_col >= 0 && c == rst_col + 1) begin
                @(negedge clk);
                check_zero("mid-line reset");
                check("mid-line reset h_sync_out", wide_t'(if2.h_sync_out), 0);
            end
        end
        step();
        de  = 1'b0;
        rst = 1'b0;
        pix = PW'($urandom);
        if (run != H && rst_col < 0) begin
            err2_q.push_back(cyc + 1);
            err4_q.push_back(cyc + 1);
        end
        repeat ($urandom_range(0, 3)) step();
        line_no++;
    endtask

    int run;
    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        check("reset n2 h_sync_out", wide_t'(if2.h_sync_out), 0);
        check("reset n4 v_sync_out", wide_t'(if4.v_sync_out), 0);
        step();
        rst = 1'b0;
        step();

        repeat (3) send_line(H, 1, -1);
        repeat (3) send_line(H, 2, -1);
        send_line(40, 1, -1);
        send_line(H, 1, -1);
        send_line(70, 1, -1);
        send_line(H, 0, -1);
        send_line(H, 1, 40);
        send_line(H, 0, -1);
        repeat (10) begin
            run = ($urandom_range(0, 1) == 1) ? H : int'($urandom_range(20, 80));
            send_line(run, 0, -1);
        end
        repeat (6) step();

        check("n2 outputs outstanding",   wide_t'(q2.size()),     0);
        check("n4 outputs outstanding",   wide_t'(q4.size()),     0);
        check("n2 line_err outstanding",  wide_t'(err2_q.size()), 0);
        check("n4 line_err outstanding",  wide_t'(err4_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
